// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder slice.
// State encoding, word offset, wait-counter sizing.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int WORD_OFFSET_BITS = 2;

  // Counter holds WAIT_CYCLES-1 at most; keep at least one bit.
  function automatic int cnt_width(input int wc);
    return (wc <= 2) ? 1 : $clog2(wc);
  endfunction

endpackage

// File: rtl/resp_mem_array.sv
// DEPTH x DATA_W word storage: synchronous write, asynchronous read.
// Ports: clk, we, addr (shared read/write index), wdata, rdata.
module resp_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle load/store responder with valid/ready req and resp channels.
// Ports: clk, rst_n (sync, active-low), req_valid/ready/write/addr/wdata,
// resp_valid/ready/rdata/err. Macro MEM_RESP_ERR_EN enables
// misaligned/out-of-range error checking.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORD_W = ADDR_W - WORD_OFFSET_BITS;
  localparam int CNT_W  = cnt_width(WAIT_CYCLES);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              commit;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic              err;
  logic              we;
  logic [DATA_W-1:0] rd;

  assign req_ready = (state == IDLE) & rst_n;
  assign accept    = req_valid & req_ready;

  // With zero wait the commit edge is the acceptance edge,
  // so the live request feeds the access directly.
  assign acc_write = (state == IDLE) ? req_write : write_q;
  assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;

  assign word = acc_addr[ADDR_W-1:WORD_OFFSET_BITS];
  assign idx  = word[IDX_W-1:0];

  assign commit = (accept & ZERO_WAIT) |
                  (rst_n & (state == WAIT) & (cnt == '0));

`ifdef MEM_RESP_ERR_EN
  assign err = (acc_addr[WORD_OFFSET_BITS-1:0] != '0) |
               (word >= WORD_W'(DEPTH));
`else
  logic unused_bits;
  assign err = 1'b0;
  assign unused_bits = ^{acc_addr[WORD_OFFSET_BITS-1:0], word};
`endif

  assign we = commit & acc_write & ~err;

  resp_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (idx),
    .wdata (acc_wdata),
    .rdata (rd)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= ZERO_WAIT ? RESP : WAIT;
            cnt   <= ZERO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        resp_valid <= 1'b1;
        resp_rdata <= (acc_write | err) ? '0 : rd;
        resp_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (WAIT_CYCLES=2 and 0 instances).
// Table vectors, hand sequences and a random run against a word-array model.
module tb_mem_responder;

`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        req_valid1, req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] mem [64];

  typedef struct {
    string       name;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)
  ) dut0w (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: word array indexed by byte address / 4.
  function automatic void model(input bit w,
                                input logic [31:0] a,
                                input logic [31:0] d,
                                output logic [31:0] rd,
                                output bit er);
    int unsigned wi = a / 4;
    er = 1'b0;
    if (ERR_EN) er = (a % 4 != 0) || (wi >= 64);
    else wi = wi % 64;
    rd = '0;
    if (!er) begin
      if (w) mem[wi] = d;
      else rd = mem[wi];
    end
  endfunction

  task automatic xact(input bit w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd,
                      output bit er);
    int n;
    int acc;
    rd = '0;
    er = 1'b0;
    @(negedge clk);
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready %b expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_latency", 32'(cyc - acc), 32'd2);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk);
    #1;
    chk("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  task automatic run(input string nm, input bit w,
                     input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd, erd;
    bit er, eer;
    model(w, a, d, erd, eer);
    xact(w, a, d, rd, er);
    chk({nm, "_rdata"}, rd, erd);
    chk({nm, "_err"}, 32'(er), 32'(eer));
  endtask

  task automatic b2b(input bit which, input int gap);
    int acc [$];
    int n;
    @(negedge clk);
    req_write = 1'b1;
    req_addr = 32'h40;
    req_wdata = 32'h5555AAAA;
    resp_ready = 1'b1;
    if (which) req_valid1 = 1'b1;
    else req_valid = 1'b1;
    n = 0;
    while (acc.size() < 4 && n < 60) begin
      if (which ? req_ready1 : req_ready) acc.push_back(cyc + 1);
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    req_valid1 = 1'b0;
    chk(which ? "b2b0_count" : "b2b2_count",
        32'(acc.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++)
      chk(which ? "b2b0_gap" : "b2b2_gap",
          32'(acc[i] - acc[i-1]), 32'(gap));
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, prior;
    bit er;
    int n;

    tbl[0] = '{"st_10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1] = '{"ld_10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{"st_00", 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0};
    tbl[3] = '{"ld_12", 1'b0, 32'h12, 32'h0,
               ERR_EN ? 32'h0 : 32'hDEADBEEF, ERR_EN};
    tbl[4] = '{"st_100", 1'b1, 32'h100, 32'hCAFEF00D, 32'h0, ERR_EN};
    tbl[5] = '{"ld_00", 1'b0, 32'h0, 32'h0,
               ERR_EN ? 32'h12345678 : 32'hCAFEF00D, 1'b0};
    tbl[6] = '{"ld_03", 1'b0, 32'h3, 32'h0,
               ERR_EN ? 32'h0 : 32'hCAFEF00D, ERR_EN};
    tbl[7] = '{"st_fc", 1'b1, 32'hFC, 32'hA5A5A5A5, 32'h0, 1'b0};
    tbl[8] = '{"ld_fc", 1'b0, 32'hFC, 32'h0, 32'hA5A5A5A5, 1'b0};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_valid1 = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_valid_w0", 32'(resp_valid1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 64; i++)
      run("fill", 1'b1, 32'(i * 4), $urandom);

    for (int i = 0; i < 9; i++) begin
      logic [31:0] mrd;
      bit mer;
      model(tbl[i].write, tbl[i].addr, tbl[i].wdata, mrd, mer);
      xact(tbl[i].write, tbl[i].addr, tbl[i].wdata, rd, er);
      chk({tbl[i].name, "_rdata"}, rd, tbl[i].rdata);
      chk({tbl[i].name, "_err"}, 32'(er), 32'(tbl[i].err));
    end

    // Backpressure on a load of 0x10 with a competing request held.
    @(negedge clk);
    req_write = 1'b0;
    req_addr = 32'h10;
    req_valid = 1'b1;
    resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_addr = 32'h20;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_resp_valid", 32'(resp_valid), 32'd1);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_rdata", resp_rdata, 32'hDEADBEEF);
      chk("bp_hold_err", 32'(resp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("bp_no_accept_valid", 32'(resp_valid), 32'd0);
    chk("bp_no_accept_ready", 32'(req_ready), 32'd1);

    // Reset through WAIT and the commit edge of a store.
    prior = mem[8];
    @(negedge clk);
    req_write = 1'b1;
    req_addr = 32'h20;
    req_wdata = 32'h11111111;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 32'h20, 32'h0, rd, er);
    chk("mid_rst_prior", rd, prior);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 511))
                                      : 32'($urandom_range(0, 63) * 4);
      run("rand", 1'($urandom_range(0, 1)), a, $urandom);
    end

    b2b(1'b0, 4);
    b2b(1'b1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
